// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MISS_REQ  = 3'd1,
        ST_MISS_WAIT = 3'd2,
        ST_WR_REQ    = 3'd3,
        ST_RESP      = 3'd4
    } cache_state_t;

    // Set index width: word offset is the low two address bits.
    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

    // Tag is everything above the index.
    function automatic int tag_width(input int addr_width, input int sets);
        return addr_width - 2 - $clog2(sets);
    endfunction

    // Age (and way-number) width; a single way still needs one bit to carry it.
    function automatic int age_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age vector for one set: next-age computation and victim choice.
module cache_lru
    import cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int AGE_W = age_width(WAYS)
) (
    input  logic [WAYS-1:0][AGE_W-1:0] ages_i,
    input  logic [WAYS-1:0]            valid_i,
    input  logic [AGE_W-1:0]           touch_way_i,
    input  logic                       update_i,
    output logic [WAYS-1:0][AGE_W-1:0] ages_o,
    output logic [AGE_W-1:0]           victim_o
);

    generate
        if (WAYS == 1) begin : gen_direct
            // Direct-mapped: the only way is always age 0 and always the victim.
            assign ages_o   = '0;
            assign victim_o = '0;
        end else begin : gen_lru
            // Touched way becomes youngest; every younger way ages by one.
            always_comb begin
                ages_o = ages_i;
                if (update_i) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (ages_i[w] < ages_i[touch_way_i]) begin
                            ages_o[w] = ages_i[w] + AGE_W'(1);
                        end
                    end
                    ages_o[touch_way_i] = '0;
                end
            end

            // Lowest invalid way wins; with a full set, the oldest way goes.
            always_comb begin
                victim_o = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (ages_i[w] == AGE_W'(WAYS - 1)) begin
                        victim_o = AGE_W'(w);
                    end
                end
                for (int w = WAYS - 1; w >= 0; w--) begin
                    if (!valid_i[w]) begin
                        victim_o = AGE_W'(w);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative, write-through, no-write-allocate, one-word-line data cache.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The core port accepts only in IDLE. The memory request is registered
// and, once raised, keeps we/addr/wdata stable until mem_req_ready is seen.
module cache_nway
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 8,
    parameter int WAYS       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  hit,
    output logic                  mem_req_valid,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output cache_state_t          dbg_state
);

    localparam int IDX_W = index_width(SETS);
    localparam int TAG_W = tag_width(ADDR_WIDTH, SETS);
    localparam int AGE_W = age_width(WAYS);

    cache_state_t state_q, state_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic                  mem_req_we_q, mem_req_we_d;
    logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [DATA_WIDTH-1:0] mem_req_wdata_q, mem_req_wdata_d;
    logic                  hit_q, hit_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [WAYS-1:0]                 valid_q [SETS];
    logic [WAYS-1:0]                 valid_d [SETS];
    logic [WAYS-1:0][TAG_W-1:0]      tag_q   [SETS];
    logic [WAYS-1:0][TAG_W-1:0]      tag_d   [SETS];
    logic [WAYS-1:0][DATA_WIDTH-1:0] data_q  [SETS];
    logic [WAYS-1:0][DATA_WIDTH-1:0] data_d  [SETS];
    logic [WAYS-1:0][AGE_W-1:0]      age_q   [SETS];
    logic [WAYS-1:0][AGE_W-1:0]      age_d   [SETS];

    // Byte-offset bits never select anything in a word-line cache.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[1:0];

    // Request fields are looked up live; fill fields come from the latched miss address.
    logic [IDX_W-1:0] req_idx, fill_idx, set_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    assign req_idx  = req_addr[2 +: IDX_W];
    assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign fill_idx = mem_req_addr_q[2 +: IDX_W];
    assign fill_tag = mem_req_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign set_idx  = (state_q == ST_IDLE) ? req_idx : fill_idx;

    logic             hit_any;
    logic [AGE_W-1:0] hit_way;

    // Tag compare across the ways of the requested set; at most one can match.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    logic                       accept, fill, lru_update;
    logic [AGE_W-1:0]           victim, touch_way;
    logic [WAYS-1:0][AGE_W-1:0] ages_next;

    assign accept     = req_valid && (state_q == ST_IDLE);
    assign fill       = (state_q == ST_MISS_WAIT) && mem_resp_valid;
    assign lru_update = (accept && hit_any) || fill;
    assign touch_way  = fill ? victim : hit_way;

    cache_lru #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_lru (
        .ages_i      (age_q[set_idx]),
        .valid_i     (valid_q[set_idx]),
        .touch_way_i (touch_way),
        .update_i    (lru_update),
        .ages_o      (ages_next),
        .victim_o    (victim)
    );

    // Next-state, memory request, response and array updates.
    always_comb begin
        state_d         = state_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_we_d    = mem_req_we_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        hit_d           = hit_q;
        rdata_d         = rdata_q;
        valid_d         = valid_q;
        tag_d           = tag_q;
        data_d          = data_q;
        age_d           = age_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mem_req_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_req_wdata_d = req_wdata;
                    mem_req_we_d    = req_we;
                    hit_d           = hit_any;
                    if (req_we) begin
                        mem_req_valid_d = 1'b1;
                        state_d         = ST_WR_REQ;
                        if (hit_any) begin
                            data_d[req_idx][hit_way] = req_wdata;
                        end
                    end else if (hit_any) begin
                        rdata_d = data_q[req_idx][hit_way];
                        state_d = ST_RESP;
                    end else begin
                        mem_req_valid_d = 1'b1;
                        state_d         = ST_MISS_REQ;
                    end
                end
            end
            ST_MISS_REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = ST_MISS_WAIT;
                end
            end
            ST_MISS_WAIT: begin
                if (mem_resp_valid) begin
                    valid_d[fill_idx][victim] = 1'b1;
                    tag_d[fill_idx][victim]   = fill_tag;
                    data_d[fill_idx][victim]  = mem_resp_rdata;
                    rdata_d                   = mem_resp_rdata;
                    hit_d                     = 1'b0;
                    state_d                   = ST_RESP;
                end
            end
            ST_WR_REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (lru_update) begin
            age_d[set_idx] = ages_next;
        end
    end

    // State and storage registers; reset empties the cache and seeds ages 0..WAYS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            hit_q           <= 1'b0;
            rdata_q         <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                tag_q[s]   <= '0;
                data_q[s]  <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            state_q         <= state_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            hit_q           <= hit_d;
            rdata_q         <= rdata_d;
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            data_q          <= data_d;
            age_q           <= age_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = (state_q == ST_RESP);
    assign hit           = resp_valid && hit_q;
    assign resp_rdata    = rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_we    = mem_req_we_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway (SETS=8, WAYS=2) with a reactive memory model.
module tb_cache_nway;
    import cache_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, hit;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    cache_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // {is_store, hit, rdata}
    logic [33:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_data;
        int          stall;
        logic        exp_mem;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    cache_nway #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .SETS       (8),
        .WAYS       (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .hit            (hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .dbg_state      (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] md, input int stall, input logic em,
                                input logic eh, input logic [31:0] er);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.mem_data = md; v.stall = stall;
        v.exp_mem = em; v.exp_hit = eh; v.exp_rdata = er;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, act as memory, and score the response.
    task automatic run_txn(input vec_t v);
        logic [31:0] word_addr, seen_addr;
        logic [33:0] e;
        logic        seen_we;
        bit          saw_mem, hs_read, hs_last, done;
        int          stall, lat, exp_lat;
        word_addr = {v.addr[31:2], 2'b00};
        exp_lat   = !v.exp_mem ? 0 : ((v.we ? 1 : 2) + v.stall);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        exp_q.push_back({v.we, v.exp_hit, v.exp_rdata});
        step();
        req_valid = 1'b0; req_we = 1'b0;
        req_addr  = $urandom; req_wdata = $urandom;
        stall = v.stall; saw_mem = 0; hs_read = 0; hs_last = 0; done = 0; lat = 0;
        seen_addr = '0; seen_we = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (hs_last) begin
                check("mem_valid_drop", mem_req_valid, 0);
                hs_last = 0;
            end
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (resp_valid) begin
                lat  = cyc;
                done = 1;
                break;
            end
            if (hs_read) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = v.mem_data;
                hs_read = 0;
            end else if (mem_req_valid) begin
                check("req_ready_stall", req_ready, 0);
                if (!saw_mem) begin
                    saw_mem   = 1;
                    seen_addr = mem_req_addr;
                    seen_we   = mem_req_we;
                end else begin
                    check("mem_addr_stable", mem_req_addr, seen_addr);
                    check("mem_we_stable", mem_req_we, seen_we);
                end
                if (stall > 0) begin
                    stall--;
                end else begin
                    mem_req_ready = 1'b1;
                    hs_last = 1;
                    hs_read = !mem_req_we;
                end
            end
            step();
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        if (!done) begin
            check("resp_timeout", 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            check("resp_hit", hit, e[32]);
            if (!e[33]) check("resp_rdata", resp_rdata, e[31:0]);
            check("resp_latency", lat, exp_lat);
            check("mem_access", saw_mem, v.exp_mem);
            if (saw_mem && v.exp_mem) begin
                check("mem_addr", seen_addr, word_addr);
                check("mem_we", seen_we, v.we);
            end
        end
        step();
        check("resp_pulse", resp_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;

        // Vector table: {we, addr, wdata, mem_data, stall, exp_mem, exp_hit, exp_rdata}
        vecs.push_back(mk(0, 32'h100, 0, 32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF)); // cold miss
        vecs.push_back(mk(0, 32'h100, 0, 0,            0, 0, 1, 32'hDEADBEEF)); // hit
        vecs.push_back(mk(1, 32'h100, 32'h12345678, 0, 0, 1, 1, 0));            // store hit
        vecs.push_back(mk(0, 32'h100, 0, 0,            0, 0, 1, 32'h12345678)); // sees store
        vecs.push_back(mk(1, 32'h200, 32'h0BADF00D, 0, 0, 1, 0, 0));            // store miss
        vecs.push_back(mk(0, 32'h200, 0, 32'hD0000200, 0, 1, 0, 32'hD0000200)); // not allocated
        vecs.push_back(mk(0, 32'h000, 0, 32'hD0000000, 0, 1, 0, 32'hD0000000)); // evicts 0x100
        vecs.push_back(mk(0, 32'h020, 0, 32'hD0000020, 0, 1, 0, 32'hD0000020)); // evicts 0x200
        vecs.push_back(mk(0, 32'h040, 0, 32'hD0000040, 0, 1, 0, 32'hD0000040)); // evicts 0x000
        vecs.push_back(mk(0, 32'h020, 0, 0,            0, 0, 1, 32'hD0000020));
        vecs.push_back(mk(0, 32'h000, 0, 32'hD1000000, 0, 1, 0, 32'hD1000000)); // evicts 0x040
        vecs.push_back(mk(0, 32'h000, 0, 0,            0, 0, 1, 32'hD1000000)); // A
        vecs.push_back(mk(0, 32'h020, 0, 0,            0, 0, 1, 32'hD0000020)); // B
        vecs.push_back(mk(0, 32'h000, 0, 0,            0, 0, 1, 32'hD1000000)); // A refreshed
        vecs.push_back(mk(0, 32'h040, 0, 32'hD1000040, 0, 1, 0, 32'hD1000040)); // C evicts B
        vecs.push_back(mk(0, 32'h000, 0, 0,            0, 0, 1, 32'hD1000000)); // A hits
        vecs.push_back(mk(0, 32'h020, 0, 32'hD1000020, 0, 1, 0, 32'hD1000020)); // B misses
        vecs.push_back(mk(0, 32'h004, 0, 32'hD0000004, 0, 1, 0, 32'hD0000004)); // set 1
        vecs.push_back(mk(0, 32'h004, 0, 0,            0, 0, 1, 32'hD0000004));
        vecs.push_back(mk(0, 32'h01C, 0, 32'hD000001C, 5, 1, 0, 32'hD000001C)); // backpressure
        vecs.push_back(mk(0, 32'h01F, 0, 0,            0, 0, 1, 32'hD000001C)); // byte bits ignored
        vecs.push_back(mk(1, 32'h004, 32'hCAFEF00D, 0, 2, 1, 1, 0));            // stalled store
        vecs.push_back(mk(0, 32'h004, 0, 0,            0, 0, 1, 32'hCAFEF00D));

        // Reset state
        step();
        step();
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_hit", hit, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_req_we", mem_req_we, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i]);
        end

        // Reset during MISS_WAIT, then a stray memory response in IDLE.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300;
        step();
        req_valid = 1'b0;
        check("rm_mem_req_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("rm_state_wait", 32'(dbg_state), 32'(ST_MISS_WAIT));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rm_req_ready", req_ready, 1);
        check("rm_mem_req_valid_low", mem_req_valid, 0);
        check("rm_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55555555;
        step();
        mem_resp_valid = 1'b0;
        check("rm_stray_resp", resp_valid, 0);
        check("rm_stray_idle", req_ready, 1);
        run_txn(mk(0, 32'h100, 0, 32'h77777777, 0, 1, 0, 32'h77777777));
        run_txn(mk(0, 32'h020, 0, 32'h88888888, 0, 1, 0, 32'h88888888));
        run_txn(mk(0, 32'h100, 0, 0,            0, 0, 1, 32'h77777777));

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
